// File: rtl/mult_arb_pkg.sv
// Shared types for mult_arbiter: FSM state encoding, default operand width and
// the requester-ID width helper.
package mult_arb_pkg;

    localparam int WIDTH_M_DEF = 16;
    localparam int NUM_REQ_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } mult_arb_state_e;

    // A single requester still needs a 1-bit ID field.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Client request / multiplier / response bundle around mult_arbiter.
// The master modport is the arbiter's view; slave is the surrounding logic.
interface mult_arbiter_if
    import mult_arb_pkg::*;
#(
    parameter int WIDTH_M = WIDTH_M_DEF,
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = id_w(NUM_REQ)
);
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0][WIDTH_M-1:0] req_a;
    logic [NUM_REQ-1:0][WIDTH_M-1:0] req_b;
    logic [NUM_REQ-1:0]              req_ready;

    logic                            mul_start;
    logic [WIDTH_M-1:0]              mul_a;
    logic [WIDTH_M-1:0]              mul_b;
    logic                            mul_done;
    logic [2*WIDTH_M-1:0]            mul_product;

    logic                            rsp_valid;
    logic [ID_W-1:0]                 rsp_id;
    logic [2*WIDTH_M-1:0]            rsp_product;
    logic                            rsp_ready;
    logic                            busy;

    modport master (
        input  req_valid, req_a, req_b,
        output req_ready,
        output mul_start, mul_a, mul_b,
        input  mul_done, mul_product,
        output rsp_valid, rsp_id, rsp_product,
        input  rsp_ready,
        output busy
    );

    modport slave (
        output req_valid, req_a, req_b,
        input  req_ready,
        input  mul_start, mul_a, mul_b,
        output mul_done, mul_product,
        input  rsp_valid, rsp_id, rsp_product,
        output rsp_ready,
        input  busy
    );

endinterface

// File: rtl/mult_arbiter_rr_arbiter.sv
// Combinational rotating-priority pick: the first set request strictly after
// last_grant_i (mod NUM_REQ), returned as one-hot, index and any flag.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_grant_i,
    output logic [NUM_REQ-1:0] gnt_oh_o,
    output logic [ID_W-1:0]    gnt_idx_o,
    output logic               any_o
);

    // One extra bit so last_grant + NUM_REQ never wraps before the modulo.
    logic [ID_W:0] pos;

    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        pos       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos = {1'b0, last_grant_i} + (ID_W+1)'(k);
            if (pos >= (ID_W+1)'(NUM_REQ)) begin
                pos = pos - (ID_W+1)'(NUM_REQ);
            end
            if (!any_o && req_i[pos[ID_W-1:0]]) begin
                any_o                     = 1'b1;
                gnt_idx_o                 = pos[ID_W-1:0];
                gnt_oh_o[pos[ID_W-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin front end sharing one sequential multiplier between NUM_REQ clients.
// Optional MULT_ARB_ZERO_BYPASS_EN answers zero-operand requests without the multiplier.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int WIDTH_M = WIDTH_M_DEF,
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = id_w(NUM_REQ)
) (
    input  logic          clk,
    input  logic          reset,
    mult_arbiter_if.master bus
);

    localparam int PW = 2 * WIDTH_M;

    mult_arb_state_e      state_q, state_d;
    logic [ID_W-1:0]      gid_q, gid_d;
    logic [ID_W-1:0]      last_q, last_d;
    logic [WIDTH_M-1:0]   a_q, a_d;
    logic [WIDTH_M-1:0]   b_q, b_d;
    logic [PW-1:0]        prod_q, prod_d;

    logic [NUM_REQ-1:0]   gnt_oh;
    logic [ID_W-1:0]      gnt_idx;
    logic                 gnt_any;
    logic [WIDTH_M-1:0]   sel_a;
    logic [WIDTH_M-1:0]   sel_b;
    logic                 accept;
    logic                 zero_op;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req_i        (bus.req_valid),
        .last_grant_i (last_q),
        .gnt_oh_o     (gnt_oh),
        .gnt_idx_o    (gnt_idx),
        .any_o        (gnt_any)
    );

    assign sel_a  = bus.req_a[gnt_idx];
    assign sel_b  = bus.req_b[gnt_idx];
    // Accept is suppressed while reset is asserted so no client sees a phantom handshake.
    assign accept = (state_q == IDLE) && gnt_any && !reset;

`ifdef MULT_ARB_ZERO_BYPASS_EN
    assign zero_op = (sel_a == '0) || (sel_b == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gid_d   = gid_q;
        last_d  = last_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    gid_d = gnt_idx;
                    a_d   = sel_a;
                    b_d   = sel_b;
                    if (zero_op) begin
                        prod_d  = '0;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.mul_done) begin
                    prod_d  = bus.mul_product;
                    state_d = RESP;
                end
            end
            RESP: begin
                // Priority only rotates once the response has actually been taken.
                if (bus.rsp_ready) begin
                    last_d  = gid_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gid_q   <= '0;
            last_q  <= ID_W'(NUM_REQ - 1);
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            gid_q   <= gid_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
        end
    end

    assign bus.req_ready   = accept ? gnt_oh : '0;
    assign bus.mul_start   = (state_q == ISSUE);
    assign bus.mul_a       = a_q;
    assign bus.mul_b       = b_q;
    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_id      = gid_q;
    assign bus.rsp_product = prod_q;
    assign bus.busy        = (state_q != IDLE);

endmodule
